// File: rtl/sd_emmc_fifo_pkg.sv
// +----------------------------------------------------------------------------+
// | sd_emmc_fifo_pkg : shared widths/defaults for the SD/eMMC sync FIFO family |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package sd_emmc_fifo_pkg;

    localparam int SD_FIFO_W     = 32;
    localparam int SD_FIFO_DEPTH = 128;

    function automatic int clog2_w(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Fill level must represent 0..DEPTH inclusive, hence one bit over the address.
    function automatic int lvl_width(input int depth);
        return clog2_w(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sd_emmc_sync_fifo_if.sv
// +----------------------------------------------------------------------------+
// | sd_emmc_sync_fifo_if : push/pop/status bundle of the SD/eMMC sync FIFO     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sd_emmc_sync_fifo_if
    import sd_emmc_fifo_pkg::*;
#(
    parameter int DATA_W = SD_FIFO_W,
    parameter int DEPTH  = SD_FIFO_DEPTH
) ();

    localparam int LVL_W = lvl_width(DEPTH);

    logic              flush_i;
    logic              wr_en_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              full_o;
    logic              almost_full_o;
    logic              rd_en_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              empty_o;
    logic              almost_empty_o;
    logic [LVL_W-1:0]  level_o;
    logic              overflow_o;
    logic              underflow_o;
    logic              err_clr_i;

    modport master (
        output flush_i, wr_en_i, wr_data_i, rd_en_i, err_clr_i,
        input  full_o, almost_full_o, rd_data_o, rd_valid_o, empty_o,
               almost_empty_o, level_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, wr_en_i, wr_data_i, rd_en_i, err_clr_i,
        output full_o, almost_full_o, rd_data_o, rd_valid_o, empty_o,
               almost_empty_o, level_o, overflow_o, underflow_o
    );

endinterface

`default_nettype wire

// File: rtl/sd_emmc_fifo_ram.sv
// +----------------------------------------------------------------------------+
// | sd_emmc_fifo_ram : DEPTH x DATA_W storage, sync write, async read, no reset|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module sd_emmc_fifo_ram
    import sd_emmc_fifo_pkg::*;
#(
    parameter int DATA_W = SD_FIFO_W,
    parameter int DEPTH  = SD_FIFO_DEPTH,
    parameter int AW     = clog2_w(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [AW-1:0]     waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [AW-1:0]     raddr,
    output logic      [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/sd_emmc_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | sd_emmc_sync_fifo : single-clock data FIFO with level, thresholds, flush   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module sd_emmc_sync_fifo
    import sd_emmc_fifo_pkg::*;
#(
    parameter int DATA_W   = SD_FIFO_W,
    parameter int DEPTH    = SD_FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 1
) (
    input wire logic         aclk,
    input wire logic         rst,
    sd_emmc_sync_fifo_if.slave bus
);

    localparam int AW = clog2_w(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] c_full_lvl = PW'(DEPTH);
    localparam logic [PW-1:0] c_af_lvl   = PW'(AF_LEVEL);
    localparam logic [PW-1:0] c_ae_lvl   = PW'(AE_LEVEL);
    localparam logic [PW-1:0] c_one      = PW'(1);

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_level;
    logic [PW-1:0]     w_wr_ptr_nxt;
    logic [PW-1:0]     w_rd_ptr_nxt;
    logic [PW-1:0]     w_level_nxt;
    logic              r_full;
    logic              r_afull;
    logic              r_empty;
    logic              r_aempty;
    logic              r_ovf;
    logic              r_unf;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic [DATA_W-1:0] w_ram_rdata;

    // Accept decisions look only at registered flags; a pop cannot make room
    // for a push in the same cycle.
    assign w_push    = bus.wr_en_i & ~r_full;
    assign w_pop     = bus.rd_en_i & ~r_empty;
    assign w_ovf_set = bus.wr_en_i & r_full;
    assign w_unf_set = bus.rd_en_i & r_empty;

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (bus.flush_i) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + c_one;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + c_one;
            end
        end
        w_level_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == c_full_lvl);
            r_afull  <= (w_level_nxt >= c_af_lvl);
            r_empty  <= (w_level_nxt == '0);
            r_aempty <= (w_level_nxt <= c_ae_lvl);
        end
    end

    // Sticky errors survive flush; a fresh error outranks a same-cycle clear.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~bus.err_clr_i);
            r_unf <= w_unf_set | (r_unf & ~bus.err_clr_i);
        end
    end

    sd_emmc_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (aclk),
        .we    (w_push & ~bus.flush_i),
        .waddr (r_wr_ptr[AW-1:0]),
        .wdata (bus.wr_data_i),
        .raddr (r_rd_ptr[AW-1:0]),
        .rdata (w_ram_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rd_data_o  = r_empty ? '0 : w_ram_rdata;
            assign bus.rd_valid_o = ~r_empty;
        end else begin : g_regrd
            logic [DATA_W-1:0] r_rd_data;
            logic              r_rd_valid;

            always_ff @(posedge aclk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_pop & ~bus.flush_i;
                    if (w_pop & ~bus.flush_i) begin
                        r_rd_data <= w_ram_rdata;
                    end
                end
            end

            assign bus.rd_data_o  = r_rd_data;
            assign bus.rd_valid_o = r_rd_valid;
        end
    endgenerate

    assign bus.level_o        = r_level;
    assign bus.full_o         = r_full;
    assign bus.almost_full_o  = r_afull;
    assign bus.empty_o        = r_empty;
    assign bus.almost_empty_o = r_aempty;
    assign bus.overflow_o     = r_ovf;
    assign bus.underflow_o    = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_sd_emmc_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | tb_sd_emmc_sync_fifo : directed bench, FWFT=1 and FWFT=0 instances, DEPTH=8|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sd_emmc_sync_fifo;

    logic aclk = 1'b0;
    logic rst  = 1'b1;

    always #5 aclk = ~aclk;

    sd_emmc_sync_fifo_if #(.DATA_W(8), .DEPTH(8)) ia ();
    sd_emmc_sync_fifo_if #(.DATA_W(8), .DEPTH(8)) ib ();

    sd_emmc_sync_fifo #(
        .DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)
    ) u_dut_a (
        .aclk (aclk),
        .rst  (rst),
        .bus  (ia)
    );

    sd_emmc_sync_fifo #(
        .DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)
    ) u_dut_b (
        .aclk (aclk),
        .rst  (rst),
        .bus  (ib)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ia.flush_i = 0; ia.wr_en_i = 0; ia.wr_data_i = '0; ia.rd_en_i = 0; ia.err_clr_i = 0;
        ib.flush_i = 0; ib.wr_en_i = 0; ib.wr_data_i = '0; ib.rd_en_i = 0; ib.err_clr_i = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_level",  ia.level_o, 0);
        check("rst_empty",  ia.empty_o, 1);
        check("rst_ae",     ia.almost_empty_o, 1);
        check("rst_full",   ia.full_o, 0);
        check("rst_af",     ia.almost_full_o, 0);
        check("rst_ovf",    ia.overflow_o, 0);
        check("rst_unf",    ia.underflow_o, 0);
        check("rst_valid",  ia.rd_valid_o, 0);
        check("rst_data",   ia.rd_data_o, 0);
        check("rst_valid_b", ib.rd_valid_o, 0);
        check("rst_data_b",  ib.rd_data_o, 0);

        // Fill 0x11..0x18 and watch level and threshold flags climb.
        for (int i = 0; i < 8; i++) begin
            ia.wr_en_i = 1; ia.wr_data_i = 8'(8'h11 + i);
            tick();
            check("fill_level", ia.level_o, i + 1);
            check("fill_af",    ia.almost_full_o, 32'((i + 1) >= 6));
            check("fill_full",  ia.full_o, 32'((i + 1) == 8));
            check("fill_ae",    ia.almost_empty_o, 32'((i + 1) <= 2));
        end
        ia.wr_data_i = 8'h99;
        tick();
        ia.wr_en_i = 0;
        check("ovf_set",   ia.overflow_o, 1);
        check("ovf_level", ia.level_o, 8);
        for (int i = 0; i < 8; i++) begin
            check("drain_data", ia.rd_data_o, 32'h11 + i);
            ia.rd_en_i = 1;
            tick();
        end
        ia.rd_en_i = 0;
        check("drain_empty", ia.empty_o, 1);
        check("drain_data0", ia.rd_data_o, 0);
        check("drain_valid", ia.rd_valid_o, 0);
        ia.err_clr_i = 1; tick(); ia.err_clr_i = 0;
        check("ovf_clr", ia.overflow_o, 0);

        // First-word fall-through of a single word.
        ia.wr_en_i = 1; ia.wr_data_i = 8'hA5; tick(); ia.wr_en_i = 0;
        check("fwft_valid", ia.rd_valid_o, 1);
        check("fwft_data",  ia.rd_data_o, 32'hA5);
        tick();
        check("fwft_hold",  ia.rd_data_o, 32'hA5);
        ia.rd_en_i = 1; tick(); ia.rd_en_i = 0;
        check("fwft_empty", ia.empty_o, 1);
        check("fwft_zero",  ia.rd_data_o, 0);

        // Underflow, then clear racing with a new underflow (set wins).
        ia.rd_en_i = 1; tick(); ia.rd_en_i = 0;
        check("unf_set",   ia.underflow_o, 1);
        check("unf_level", ia.level_o, 0);
        ia.err_clr_i = 1; ia.rd_en_i = 1; tick(); ia.err_clr_i = 0; ia.rd_en_i = 0;
        check("unf_setwins", ia.underflow_o, 1);
        ia.err_clr_i = 1; tick(); ia.err_clr_i = 0;
        check("unf_clr", ia.underflow_o, 0);

        // Full: simultaneous push+pop rejects the push.
        for (int i = 0; i < 8; i++) begin
            ia.wr_en_i = 1; ia.wr_data_i = 8'(8'h20 + i); tick();
        end
        ia.wr_data_i = 8'h77; ia.rd_en_i = 1; tick();
        ia.wr_en_i = 0; ia.rd_en_i = 0;
        check("fullpp_level", ia.level_o, 7);
        check("fullpp_ovf",   ia.overflow_o, 1);
        for (int i = 0; i < 7; i++) begin
            check("fullpp_data", ia.rd_data_o, 32'h21 + i);
            ia.rd_en_i = 1; tick();
        end
        ia.rd_en_i = 0;
        check("fullpp_empty", ia.empty_o, 1);
        ia.err_clr_i = 1; tick(); ia.err_clr_i = 0;

        // Level 4 streaming across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            ia.wr_en_i = 1; ia.wr_data_i = 8'(8'h30 + i); tick();
        end
        for (int k = 0; k < 20; k++) begin
            check("wrap_head", ia.rd_data_o, (k < 4) ? (32'h30 + k) : (32'h40 + k - 4));
            ia.wr_en_i = 1; ia.wr_data_i = 8'(8'h40 + k); ia.rd_en_i = 1;
            tick();
            check("wrap_level", ia.level_o, 4);
        end
        ia.wr_en_i = 0;
        for (int i = 0; i < 4; i++) begin
            check("wrap_tail", ia.rd_data_o, 32'h50 + i);
            tick();
        end
        ia.rd_en_i = 0;
        check("wrap_empty", ia.empty_o, 1);

        // Flush at level 5 with overflow pending and a same-cycle push.
        for (int i = 0; i < 9; i++) begin
            ia.wr_en_i = 1; ia.wr_data_i = 8'(8'h60 + i); tick();
        end
        ia.wr_en_i = 0;
        ia.rd_en_i = 1; tick(); tick(); tick(); ia.rd_en_i = 0;
        check("pre_flush_level", ia.level_o, 5);
        ia.flush_i = 1; ia.wr_en_i = 1; ia.wr_data_i = 8'hEE; tick();
        ia.flush_i = 0; ia.wr_en_i = 0;
        check("flush_level", ia.level_o, 0);
        check("flush_empty", ia.empty_o, 1);
        check("flush_ae",    ia.almost_empty_o, 1);
        check("flush_af",    ia.almost_full_o, 0);
        check("flush_valid", ia.rd_valid_o, 0);
        check("flush_ovf",   ia.overflow_o, 1);
        ia.err_clr_i = 1; tick(); ia.err_clr_i = 0;
        check("flush_ovfclr", ia.overflow_o, 0);
        ia.wr_en_i = 1; ia.wr_data_i = 8'h71; tick(); ia.wr_en_i = 0;
        check("post_flush_data", ia.rd_data_o, 32'h71);
        ia.rd_en_i = 1; tick(); ia.rd_en_i = 0;

        // Asynchronous reset at level 5, sampled before the next edge.
        for (int i = 0; i < 5; i++) begin
            ia.wr_en_i = 1; ia.wr_data_i = 8'(8'h80 + i); tick();
        end
        ia.wr_en_i = 0;
        check("prerst_level", ia.level_o, 5);
        #2 rst = 1'b1;
        #1;
        check("arst_level", ia.level_o, 0);
        check("arst_empty", ia.empty_o, 1);
        check("arst_ae",    ia.almost_empty_o, 1);
        check("arst_af",    ia.almost_full_o, 0);
        check("arst_valid", ia.rd_valid_o, 0);
        check("arst_data",  ia.rd_data_o, 0);
        #2 rst = 1'b0;
        tick();
        check("arst_after", ia.level_o, 0);

        // Registered-read instance.
        for (int i = 0; i < 3; i++) begin
            ib.wr_en_i = 1; ib.wr_data_i = 8'(8'hB0 + i); tick();
        end
        ib.wr_en_i = 0;
        check("reg_novalid", ib.rd_valid_o, 0);
        ib.rd_en_i = 1; tick(); ib.rd_en_i = 0;
        check("reg_valid",  ib.rd_valid_o, 1);
        check("reg_data",   ib.rd_data_o, 32'hB0);
        check("reg_level",  ib.level_o, 2);
        tick();
        check("reg_pulse",  ib.rd_valid_o, 0);
        check("reg_hold",   ib.rd_data_o, 32'hB0);
        ib.rd_en_i = 1; tick();
        check("reg_b2b1", ib.rd_data_o, 32'hB1);
        tick(); ib.rd_en_i = 0;
        check("reg_b2b2", ib.rd_data_o, 32'hB2);
        check("reg_b2bv", ib.rd_valid_o, 1);
        tick();
        check("reg_b2bend", ib.rd_valid_o, 0);
        ib.rd_en_i = 1; tick(); ib.rd_en_i = 0;
        check("reg_unf",       ib.underflow_o, 1);
        check("reg_unf_level", ib.level_o, 0);
        check("reg_unf_valid", ib.rd_valid_o, 0);
        check("reg_unf_hold",  ib.rd_data_o, 32'hB2);
        ib.wr_en_i = 1; ib.wr_data_i = 8'hC1; tick();
        ib.wr_data_i = 8'hC2; tick(); ib.wr_en_i = 0;
        ib.rd_en_i = 1; tick();
        check("reg_c1", ib.rd_data_o, 32'hC1);
        ib.flush_i = 1; tick(); ib.flush_i = 0; ib.rd_en_i = 0;
        check("reg_flush_valid", ib.rd_valid_o, 0);
        check("reg_flush_level", ib.level_o, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
